// File: rtl/ooo_ring_pkg.sv
// Shared constants for the out-of-order result ring: functional-unit indices,
// default unit count and index-width helper.
package ooo_ring_pkg;

    localparam int NUM_FU     = 5;
    localparam int FU_LOGICAL = 0;
    localparam int FU_ARITH   = 1;
    localparam int FU_BRANCH  = 2;
    localparam int FU_LD_ST   = 3;
    localparam int FU_MUL_DIV = 4;

    // Width of the out_src / pending_cnt fields.
    localparam int SRC_W = 3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: grants the first set request found when searching
// upward from ptr, modulo N. Output is one-hot or zero.
module rr_pick #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    always_comb begin
        logic        w_found;
        logic [PW:0] w_idx;
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                gnt[w_idx[PW-1:0]] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_wb_arbiter.sv
// Writeback arbiter: one holding buffer per functional unit, round-robin
// injection of buffered results into the ring head slot.
module ring_wb_arbiter #(
    parameter int XLEN          = 32,
    parameter int PHYS_REG_SIZE = 256,
    parameter int ROB_ENTRY     = 256,
    parameter int NUM_FU        = ooo_ring_pkg::NUM_FU,
    localparam int PRW          = $clog2(PHYS_REG_SIZE),
    localparam int RBW          = $clog2(ROB_ENTRY)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_FU-1:0]      fu_valid,
    output logic [NUM_FU-1:0]      fu_ready,
    input  logic [NUM_FU*PRW-1:0]  fu_reg,
    input  logic [NUM_FU*XLEN-1:0] fu_val,
    input  logic [NUM_FU*RBW-1:0]  fu_rob,
    input  logic                   ring_slot_busy,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [PRW-1:0]         out_reg,
    output logic [XLEN-1:0]        out_val,
    output logic [RBW-1:0]         out_rob_entry,
    output logic [2:0]             out_src,
    output logic [2:0]             pending_cnt
);
    import ooo_ring_pkg::*;

    localparam int PTW = idx_width(NUM_FU);

    logic [NUM_FU-1:0] r_buf_valid;
    logic [PRW-1:0]    r_buf_reg [NUM_FU];
    logic [XLEN-1:0]   r_buf_val [NUM_FU];
    logic [RBW-1:0]    r_buf_rob [NUM_FU];

    logic              r_out_valid;
    logic [PRW-1:0]    r_out_reg;
    logic [XLEN-1:0]   r_out_val;
    logic [RBW-1:0]    r_out_rob;
    logic [SRC_W-1:0]  r_out_src;
    logic [SRC_W-1:0]  r_pending_cnt;
    logic [PTW-1:0]    r_rr_ptr;

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_gnt;
    logic [NUM_FU-1:0] w_ready;
    logic [NUM_FU-1:0] w_accept;
    logic [NUM_FU-1:0] w_buf_valid_next;
    logic              w_any_gnt;
    logic [PRW-1:0]    w_sel_reg;
    logic [XLEN-1:0]   w_sel_val;
    logic [RBW-1:0]    w_sel_rob;
    logic [SRC_W-1:0]  w_sel_src;
    logic [SRC_W-1:0]  w_pend_next;
    logic [PTW-1:0]    w_rr_next;

    // Nothing may be injected while the head slot is taken or during a flush.
    assign w_req = r_buf_valid & {NUM_FU{~ring_slot_busy & ~flush}};

    rr_pick #(
        .N  (NUM_FU),
        .PW (PTW)
    ) u_pick (
        .req (w_req),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
            // A buffer being drained this cycle can take a new result at once.
            assign w_ready[gi]          = ~rst & ~flush & (~r_buf_valid[gi] | w_gnt[gi]);
            assign w_accept[gi]         = fu_valid[gi] & w_ready[gi];
            assign w_buf_valid_next[gi] = ~flush & (w_accept[gi] | (r_buf_valid[gi] & ~w_gnt[gi]));
        end
    endgenerate

    assign fu_ready = w_ready;

    always_comb begin
        w_sel_reg   = '0;
        w_sel_val   = '0;
        w_sel_rob   = '0;
        w_sel_src   = '0;
        w_pend_next = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_gnt[i]) begin
                w_sel_reg = r_buf_reg[i];
                w_sel_val = r_buf_val[i];
                w_sel_rob = r_buf_rob[i];
                w_sel_src = SRC_W'(i);
            end
            w_pend_next = w_pend_next + SRC_W'(w_buf_valid_next[i]);
        end
        w_any_gnt = |w_gnt;
        w_rr_next = (w_sel_src == SRC_W'(NUM_FU - 1)) ? '0 : PTW'(w_sel_src) + PTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
        end else begin
            r_buf_valid <= w_buf_valid_next;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_accept[i]) begin
                r_buf_reg[i] <= fu_reg[i*PRW +: PRW];
                r_buf_val[i] <= fu_val[i*XLEN +: XLEN];
                r_buf_rob[i] <= fu_rob[i*RBW +: RBW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_reg     <= '0;
            r_out_val     <= '0;
            r_out_rob     <= '0;
            r_out_src     <= '0;
            r_pending_cnt <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_out_valid   <= w_any_gnt;
            r_pending_cnt <= w_pend_next;
            if (w_any_gnt) begin
                r_out_reg <= w_sel_reg;
                r_out_val <= w_sel_val;
                r_out_rob <= w_sel_rob;
                r_out_src <= w_sel_src;
                r_rr_ptr  <= w_rr_next;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_reg       = r_out_reg;
    assign out_val       = r_out_val;
    assign out_rob_entry = r_out_rob;
    assign out_src       = r_out_src;
    assign pending_cnt   = r_pending_cnt;

endmodule

// File: tb/tb_ring_wb_arbiter.sv
// Scoreboard bench for ring_wb_arbiter: directed stimulus pushes expected ring
// injections; a negedge monitor pops and compares every out_valid beat.
module tb_ring_wb_arbiter;

    localparam int XLEN = 32;
    localparam int PRW  = 8;
    localparam int RBW  = 8;
    localparam int N    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    fu_valid;
    logic [N-1:0]    fu_ready;
    logic [N*PRW-1:0]  fu_reg;
    logic [N*XLEN-1:0] fu_val;
    logic [N*RBW-1:0]  fu_rob;
    logic            ring_slot_busy;
    logic            flush;
    logic            out_valid;
    logic [PRW-1:0]  out_reg;
    logic [XLEN-1:0] out_val;
    logic [RBW-1:0]  out_rob_entry;
    logic [2:0]      out_src;
    logic [2:0]      pending_cnt;

    typedef struct packed {
        logic [2:0]      src;
        logic [PRW-1:0]  rg;
        logic [XLEN-1:0] val;
        logic [RBW-1:0]  rob;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    ring_wb_arbiter #(
        .XLEN          (XLEN),
        .PHYS_REG_SIZE (256),
        .ROB_ENTRY     (256),
        .NUM_FU        (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fu_valid       (fu_valid),
        .fu_ready       (fu_ready),
        .fu_reg         (fu_reg),
        .fu_val         (fu_val),
        .fu_rob         (fu_rob),
        .ring_slot_busy (ring_slot_busy),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_reg        (out_reg),
        .out_val        (out_val),
        .out_rob_entry  (out_rob_entry),
        .out_src        (out_src),
        .pending_cnt    (pending_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every injected beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got src=%0d reg=%h val=%h rob=%h, required no output",
                         out_src, out_reg, out_val, out_rob_entry);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_src, out_reg, out_val, out_rob_entry} !== mon_e) begin
                    n_fail++;
                    $display("FAIL out_beat: got src=%0d reg=%h val=%h rob=%h, required src=%0d reg=%h val=%h rob=%h",
                             out_src, out_reg, out_val, out_rob_entry,
                             mon_e.src, mon_e.rg, mon_e.val, mon_e.rob);
                end else begin
                    $display("[TB] beat src=%0d reg=%h val=%h rob=%h ok",
                             out_src, out_reg, out_val, out_rob_entry);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] %s = %h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [7:0] r, input logic [31:0] v, input logic [7:0] rb);
        fu_valid[i]           = 1'b1;
        fu_reg[i*PRW +: PRW]  = r;
        fu_val[i*XLEN +: XLEN] = v;
        fu_rob[i*RBW +: RBW]  = rb;
    endtask

    task automatic push(input int i, input logic [7:0] r, input logic [31:0] v, input logic [7:0] rb);
        exp_t e;
        e.src = 3'(i);
        e.rg  = r;
        e.val = v;
        e.rob = rb;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        fu_valid = '0;
        repeat (8) tick();
    endtask

    int k;
    logic take;

    initial begin
        rst            = 1'b1;
        fu_valid       = '1;
        fu_reg         = '0;
        fu_val         = '0;
        fu_rob         = '0;
        ring_slot_busy = 1'b0;
        flush          = 1'b0;

        // Reset state; fu_valid held high to show nothing is accepted in reset.
        #1;
        chk("rst_fu_ready", 64'(fu_ready), 64'h0);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_pending", 64'(pending_cnt), 64'h0);
        chk("rst_out_src", 64'(out_src), 64'h0);
        rst      = 1'b0;
        fu_valid = '0;
        tick();

        // Single result from the branch unit, 2-cycle latency.
        put(2, 8'h1A, 32'hDEADBEEF, 8'h05);
        push(2, 8'h1A, 32'hDEADBEEF, 8'h05);
        tick();
        fu_valid = '0;
        chk("lat_cycle1_valid", 64'(out_valid), 64'h0);
        tick();
        chk("lat_cycle2_valid", 64'(out_valid), 64'h1);
        chk("lat_cycle2_src", 64'(out_src), 64'h2);
        drain();

        // Return rr_ptr to 0, then all five units at once.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            put(i, 8'(8'h10 + i), 32'hA0000000 + 32'(i), 8'(8'h20 + i));
            push(i, 8'(8'h10 + i), 32'hA0000000 + 32'(i), 8'(8'h20 + i));
        end
        tick();
        fu_valid = '0;
        chk("all5_pending_5", 64'(pending_cnt), 64'd5);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("all5_pending_%0d", 5 - c), 64'(pending_cnt), 64'(5 - c));
        end
        drain();

        // rr_ptr -> 4 via FU3, then FU4 and FU0 contend: 4 first, then 0 (ptr wraps).
        put(3, 8'h33, 32'h33333333, 8'h03);
        push(3, 8'h33, 32'h33333333, 8'h03);
        tick();
        drain();
        put(0, 8'h70, 32'h70707070, 8'h07);
        put(4, 8'h74, 32'h74747474, 8'h0B);
        push(4, 8'h74, 32'h74747474, 8'h0B);
        push(0, 8'h70, 32'h70707070, 8'h07);
        tick();
        drain();
        // rr_ptr is now 1: FU1 wins over FU0.
        put(0, 8'h80, 32'h80808080, 8'h08);
        put(1, 8'h81, 32'h81818181, 8'h09);
        push(1, 8'h81, 32'h81818181, 8'h09);
        push(0, 8'h80, 32'h80808080, 8'h08);
        tick();
        drain();

        // FU1 streams six results while the ring slot is busy for four cycles.
        k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            ring_slot_busy = (c < 4);
            put(1, 8'(8'h40 + k), 32'hB0000000 + 32'(k), 8'(8'h50 + k));
            #1;
            if (c == 0) chk("busy_ready_first", 64'(fu_ready[1]), 64'h1);
            if (c >= 1 && c < 4) chk($sformatf("busy_ready_c%0d", c), 64'(fu_ready[1]), 64'h0);
            take = fu_ready[1];
            if (take) push(1, 8'(8'h40 + k), 32'hB0000000 + 32'(k), 8'(8'h50 + k));
            tick();
            if (take) k++;
        end
        ring_slot_busy = 1'b0;
        chk("stream_all_sent", 64'(k), 64'd6);
        drain();

        // Flush with three full buffers; none of them may ever emerge.
        ring_slot_busy = 1'b1;
        put(0, 8'h90, 32'h90909090, 8'h10);
        put(1, 8'h91, 32'h91919191, 8'h11);
        put(2, 8'h92, 32'h92929292, 8'h12);
        tick();
        fu_valid = '0;
        chk("flush_pre_pending", 64'(pending_cnt), 64'd3);
        flush = 1'b1;
        put(3, 8'h93, 32'h93939393, 8'h13);
        #1;
        chk("flush_fu_ready", 64'(fu_ready), 64'h0);
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        chk("flush_pending", 64'(pending_cnt), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        ring_slot_busy = 1'b0;
        drain();

        // Reset mid-stream: rr_ptr=2, so FU2 is injected, then rst discards the rest.
        ring_slot_busy = 1'b1;
        put(0, 8'hA0, 32'hA0A0A0A0, 8'h20);
        put(1, 8'hA1, 32'hA1A1A1A1, 8'h21);
        put(2, 8'hA2, 32'hA2A2A2A2, 8'h22);
        tick();
        fu_valid       = '0;
        ring_slot_busy = 1'b0;
        push(2, 8'hA2, 32'hA2A2A2A2, 8'h22);
        tick();
        rst = 1'b1;
        put(3, 8'hA3, 32'hA3A3A3A3, 8'h23);
        #1;
        chk("midrst_fu_ready", 64'(fu_ready), 64'h0);
        tick();
        rst      = 1'b0;
        fu_valid = '0;
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_pending", 64'(pending_cnt), 64'h0);
        chk("midrst_out_fields", 64'({out_src, out_reg, out_val, out_rob_entry}), 64'h0);
        tick();
        chk("postrst_out_valid", 64'(out_valid), 64'h0);
        drain();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
